// File: rtl/uart_pkg.sv
// Shared receiver types and 8N1 frame constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    // Mid-bit offset used to centre the start-bit check; floor division.
    function automatic int half_period(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead byte FIFO with occupancy count; head visible combinationally, 0 when empty.
// Latency: push/pop visible the cycle after the edge that samples them.
// Backpressure: push when full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;

    // A pop frees the slot a same-cycle push into a full FIFO needs.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO, with sticky frame/overrun flags and intr.
// Latency: byte visible one cycle after the mid-stop-bit sample; intr one cycle later.
// Backpressure: none on the line; a byte arriving to a full FIFO without rd_en is dropped.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err,
    output logic                          intr
);

    localparam int HALF  = half_period(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic             r_sync1;
    logic             r_rxs;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_intr;

    logic w_half_done;
    logic w_bit_done;
    logic w_cnt_clr;
    logic w_sample_dat;
    logic w_stop_smp;
    logic w_push;
    logic w_ferr_set;
    logic w_ovr_set;

    assign w_half_done = (r_cnt == CNT_W'(HALF - 1));
    assign w_bit_done  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!r_rxs) w_state_nxt = START;
            START:   if (w_half_done) w_state_nxt = r_rxs ? IDLE : DATA;
            DATA:    if (w_bit_done && r_idx == 3'(DATA_BITS - 1)) w_state_nxt = STOP;
            STOP:    if (w_bit_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_sample_dat = (r_state == DATA) && w_bit_done;
        w_stop_smp   = (r_state == STOP) && w_bit_done;
        w_cnt_clr    = (r_state == IDLE) || ((r_state == START) && w_half_done)
                    || w_sample_dat || w_stop_smp;
        w_push       = w_stop_smp && (r_rxs == STOP_LEVEL);
        w_ferr_set   = w_stop_smp && (r_rxs != STOP_LEVEL);
        w_ovr_set    = w_push && full && !rd_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_state == IDLE || r_state == START) begin
                r_idx <= '0;
            end else if (w_sample_dat) begin
                r_idx   <= r_idx + 1'b1;
                r_shift <= {r_rxs, r_shift[7:1]};
            end
        end
    end

    // Error set takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_intr      <= 1'b0;
        end else begin
            if (w_ferr_set)   r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;
            if (w_ovr_set)    r_overrun <= 1'b1;
            else if (clr_err) r_overrun <= 1'b0;
            r_intr <= !empty || r_frame_err || r_overrun;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (r_shift),
        .i_pop      (rd_en),
        .o_head_dat (rd_data),
        .o_empty    (empty),
        .o_full     (full),
        .o_count    (count)
    );

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign intr      = r_intr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit; expected bytes tracked in a scoreboard queue.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;
    logic          intr;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] exp_q[$];
    logic       ferr_m;
    logic       ovr_m;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err),
        .intr      (intr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_fifo(input string tag);
        chk({tag, " count"}, 32'(count), 32'(exp_q.size()));
        chk({tag, " empty"}, 32'(empty), 32'(exp_q.size() == 0));
        chk({tag, " full"},  32'(full),  32'(exp_q.size() == DEPTH));
        if (exp_q.size() > 0) chk({tag, " head"}, 32'(rd_data), 32'(exp_q[0]));
        else                  chk({tag, " head"}, 32'(rd_data), 32'(0));
    endtask

    // Called at a negedge; drives a full frame (160 cycles). The stop sample Ts
    // falls in the cycle ending at posedge 155, so negedge 154 is before, 155 after.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic pop_at_ts, input string tag);
        logic [9:0] frame;
        int         cnt_before;
        logic       intr_before;
        frame       = {stop_bit, b, 1'b0};
        cnt_before  = 0;
        intr_before = 1'b0;
        for (int n = 0; n < 10 * CPB; n++) begin
            rx = frame[n / CPB];
            if (n == 154) begin
                cnt_before  = exp_q.size();
                intr_before = (cnt_before != 0) | ferr_m | ovr_m;
                chk({tag, " count before Ts"}, 32'(count), 32'(cnt_before));
                if (pop_at_ts && exp_q.size() > 0) begin
                    chk({tag, " head at Ts"}, 32'(rd_data), 32'(exp_q[0]));
                    rd_en = 1'b1;
                    void'(exp_q.pop_front());
                end
                if (stop_bit) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(b);
                    else                      ovr_m = 1'b1;
                end else begin
                    ferr_m = 1'b1;
                end
            end
            if (n == 155) begin
                rd_en = 1'b0;
                chk_fifo({tag, " Ts+1"});
                chk({tag, " frame_err"}, 32'(frame_err), 32'(ferr_m));
                chk({tag, " overrun"},   32'(overrun),   32'(ovr_m));
                chk({tag, " intr Ts+1"}, 32'(intr),      32'(intr_before));
            end
            if (n == 156) begin
                chk({tag, " intr Ts+2"}, 32'(intr),
                    32'((exp_q.size() != 0) | ferr_m | ovr_m));
            end
            @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() > 0) chk({tag, " pop data"}, 32'(rd_data), 32'(exp_q[0]));
        else                  chk({tag, " pop data"}, 32'(rd_data), 32'(0));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk_fifo({tag, " after pop"});
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        ferr_m  = 1'b0;
        ovr_m   = 1'b0;
        chk("clr frame_err", 32'(frame_err), 32'(0));
        chk("clr overrun",   32'(overrun),   32'(0));
    endtask

    initial begin
        logic [9:0] part;
        rx      = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        rst_n   = 1'b0;
        ferr_m  = 1'b0;
        ovr_m   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and quiet line
        chk_fifo("reset");
        chk("reset intr",      32'(intr),      32'(0));
        chk("reset frame_err", 32'(frame_err), 32'(0));
        chk("reset overrun",   32'(overrun),   32'(0));
        repeat (200) @(negedge clk);
        chk_fifo("idle200");
        chk("idle200 intr", 32'(intr), 32'(0));

        // Back-to-back frames
        send_frame(8'h0F, 1'b1, 1'b0, "b2b0");
        send_frame(8'h3D, 1'b1, 1'b0, "b2b1");
        send_frame(8'h4F, 1'b1, 1'b0, "b2b2");
        chk("b2b count", 32'(count), 32'(3));
        repeat (3) pop_check("b2b");
        pop_check("pop empty");

        // Short glitch is rejected at the start check
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk_fifo("glitch");
        chk("glitch frame_err", 32'(frame_err), 32'(0));
        chk("glitch overrun",   32'(overrun),   32'(0));
        chk("glitch intr",      32'(intr),      32'(0));

        // Framing error, clear, then a good frame
        send_frame(8'hA5, 1'b0, 1'b0, "ferr");
        repeat (40) @(negedge clk);
        chk_fifo("ferr nopush");
        pulse_clr();
        @(negedge clk);
        chk("ferr intr cleared", 32'(intr), 32'(0));
        send_frame(8'h5A, 1'b1, 1'b0, "after_ferr");
        pop_check("after_ferr");

        // Ten frames with no pops: last two dropped
        for (int i = 0; i < 10; i++) send_frame(8'(8'h21 + i * 7), 1'b1, 1'b0, "ovr");
        chk("ovr full",    32'(full),    32'(1));
        chk("ovr count",   32'(count),   32'(8));
        chk("ovr overrun", 32'(overrun), 32'(1));
        repeat (8) pop_check("ovr drain");
        pulse_clr();

        // Full FIFO with push and rd_en in the same cycle
        for (int i = 0; i < 8; i++) send_frame(8'(8'h80 + i), 1'b1, 1'b0, "fill");
        chk("fill full", 32'(full), 32'(1));
        send_frame(8'hC3, 1'b1, 1'b1, "fullpop");
        chk("fullpop count",   32'(count),   32'(8));
        chk("fullpop overrun", 32'(overrun), 32'(0));
        repeat (8) pop_check("fullpop drain");

        // Reset in the middle of a frame
        send_frame(8'h11, 1'b1, 1'b0, "prerst");
        part = {1'b1, 8'h99, 1'b0};
        for (int n = 0; n < 60; n++) begin
            rx = part[n / CPB];
            @(negedge clk);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        ferr_m = 1'b0;
        ovr_m  = 1'b0;
        chk_fifo("midrst");
        chk("midrst intr", 32'(intr), 32'(0));
        repeat (20) @(negedge clk);
        send_frame(8'h6B, 1'b1, 1'b0, "postrst");
        pop_check("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
